text_line_cache: RTL and testbench

TEXT_LINE_CACHE -- requirements
Module: text_line_cache

---
 rtl/text_line_cache.sv | 219 +++++++++++++++++++++
 tb/tb_text_line_cache.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_cache.sv
// Ping-pong text line cache: fills one row of character codes from char memory while the other row is displayed.
// Optional attribute bit (inverse video) is enabled by defining TLC_ATTR_EN.
module text_line_cache #(
  parameter int FONT_W   = 15,
  parameter int FONT_H   = 21,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  px_x,
  input  logic [8:0]  px_y,
  input  logic        eof,
  output logic [12:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic [6:0]  char_code,
  output logic        char_inv,
  output logic        off_limits,
  output logic        busy,
  output logic        overrun
);

  localparam int COLS = SCREEN_W / FONT_W;
  localparam int ROWS = SCREEN_H / FONT_H;
  localparam int IW   = $clog2(COLS);
  localparam int LW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
`ifdef TLC_ATTR_EN
  localparam int BUF_W = 8;
`else
  localparam int BUF_W = 7;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_SWAP} state_t;

  state_t            state_q, state_d;
  logic [12:0]       col_q, col_d;
  logic [12:0]       base_q, base_d;
  logic [4:0]        row_q, row_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              bank_q, bank_d;
  logic [12:0]       addr_hold_q, addr_hold_d;
  logic [9:0]        prev_x_q, prev_x_d;
  logic              overrun_q, overrun_d;
  logic [6:0]        char_code_q, char_code_d;
  logic              char_inv_q, char_inv_d;
  logic              off_limits_q, off_limits_d;
  logic              vld_q [MEM_LAT];
  logic              vld_d [MEM_LAT];
  logic [IW-1:0]     idx_q [MEM_LAT];
  logic [IW-1:0]     idx_d [MEM_LAT];
  logic [BUF_W-1:0]  line_buf_q [2][COLS];
  logic [BUF_W-1:0]  line_buf_d [2][COLS];

  logic [9:0]  cell_x;
  logic [8:0]  y_row;
  logic [8:0]  y_mod;
  logic        row_trig;
  logic        trig;
  logic [4:0]  trig_row;
  logic        busy_w;
  logic        flush;
  logic [12:0] issue_addr;
  logic        wr_en;
  logic [IW-1:0] wr_idx;
  logic [BUF_W-1:0] wr_data;
  logic        unused_bits;

  assign cell_x     = px_x / 10'(FONT_W);
  assign y_row      = px_y / 9'(FONT_H);
  assign y_mod      = px_y % 9'(FONT_H);
  assign busy_w     = (state_q != S_IDLE);
  assign issue_addr = base_q + col_q;

  // Row trigger fires once on the rising edge into the horizontal blank of a cell's last scanline.
  assign row_trig = (px_x == 10'(SCREEN_W)) && (prev_x_q != 10'(SCREEN_W)) &&
                    (y_mod == 9'(FONT_H - 1)) && (y_row < 9'(ROWS - 1));
  assign trig     = en && (eof || row_trig);
  assign trig_row = eof ? 5'd0 : 5'(y_row + 9'd1);

  assign wr_en   = vld_q[MEM_LAT-1];
  assign wr_idx  = idx_q[MEM_LAT-1];
  assign wr_data = mem_data[BUF_W-1:0];
`ifdef TLC_ATTR_EN
  assign unused_bits = 1'b0;
`else
  assign unused_bits = mem_data[7];
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    base_d      = base_q;
    row_d       = row_q;
    lat_d       = lat_q;
    bank_d      = bank_q;
    addr_hold_d = addr_hold_q;
    flush       = 1'b0;
    if (state_q == S_ISSUE)
      addr_hold_d = issue_addr;
    if (!en) begin
      state_d = S_IDLE;
      flush   = 1'b1;
    end else if (busy_w && eof) begin
      // Abandon the partial fill; the fill bank is simply overwritten by the restart.
      state_d = S_ISSUE;
      base_d  = '0;
      col_d   = '0;
      row_d   = '0;
      flush   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trig) begin
            state_d = S_ISSUE;
            row_d   = trig_row;
            base_d  = 13'(trig_row) * 13'(COLS);
            col_d   = '0;
          end
        end
        S_ISSUE: begin
          col_d = col_q + 13'd1;
          if (col_q == 13'(COLS - 1)) begin
            state_d = S_DRAIN;
            lat_d   = '0;
          end
        end
        S_DRAIN: begin
          if (lat_q == LW'(MEM_LAT - 1))
            state_d = S_SWAP;
          else
            lat_d = lat_q + 1'b1;
        end
        S_SWAP: begin
          bank_d  = ~bank_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    vld_d[0] = (state_q == S_ISSUE) && !flush;
    idx_d[0] = col_q[IW-1:0];
    for (int i = 1; i < MEM_LAT; i++) begin
      vld_d[i] = vld_q[i-1] && !flush;
      idx_d[i] = idx_q[i-1];
    end
    line_buf_d = line_buf_q;
    if (wr_en)
      line_buf_d[~bank_q][wr_idx] = wr_data;
  end

  always_comb begin
    prev_x_d     = px_x;
    overrun_d    = overrun_q;
    if ((px_x == 10'd0) && (prev_x_q != 10'd0) && busy_w && (9'(row_q) == y_row))
      overrun_d = 1'b1;
    off_limits_d = !en || (px_x >= 10'(COLS * FONT_W)) || (px_y >= 9'(ROWS * FONT_H));
    char_code_d  = '0;
    char_inv_d   = 1'b0;
    if (!off_limits_d && (cell_x < 10'(COLS))) begin
      char_code_d = line_buf_q[bank_q][cell_x[IW-1:0]][6:0];
`ifdef TLC_ATTR_EN
      char_inv_d  = line_buf_q[bank_q][cell_x[IW-1:0]][7];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      base_q       <= '0;
      row_q        <= '0;
      lat_q        <= '0;
      bank_q       <= 1'b0;
      addr_hold_q  <= '0;
      prev_x_q     <= '0;
      overrun_q    <= 1'b0;
      char_code_q  <= '0;
      char_inv_q   <= 1'b0;
      off_limits_q <= 1'b1;
      for (int i = 0; i < MEM_LAT; i++) begin
        vld_q[i] <= 1'b0;
        idx_q[i] <= '0;
      end
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < COLS; c++)
          line_buf_q[b][c] <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      base_q       <= base_d;
      row_q        <= row_d;
      lat_q        <= lat_d;
      bank_q       <= bank_d;
      addr_hold_q  <= addr_hold_d;
      prev_x_q     <= prev_x_d;
      overrun_q    <= overrun_d;
      char_code_q  <= char_code_d;
      char_inv_q   <= char_inv_d;
      off_limits_q <= off_limits_d;
      vld_q        <= vld_d;
      idx_q        <= idx_d;
      line_buf_q   <= line_buf_d;
    end
  end

  assign mem_addr   = (state_q == S_ISSUE) ? issue_addr : addr_hold_q;
  assign char_code  = char_code_q;
  assign char_inv   = char_inv_q;
  assign off_limits = off_limits_q;
  assign busy       = busy_w;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_text_line_cache.sv
// Directed bench for text_line_cache: expectations are queued with the cycle they are due,
// and a separate monitor compares them against the DUT outputs on the falling edge.
module tb_text_line_cache;

`ifdef TLC_ATTR_EN
  localparam int ATTR = 1;
`else
  localparam int ATTR = 0;
`endif

  localparam int SIG_CODE = 0;
  localparam int SIG_INV  = 1;
  localparam int SIG_OFF  = 2;
  localparam int SIG_BUSY = 3;
  localparam int SIG_OVR  = 4;
  localparam int SIG_ADDR = 5;

  logic        clk;
  logic        rst;
  logic        en;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic        eof;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic [6:0]  char_code;
  logic        char_inv;
  logic        off_limits;
  logic        busy;
  logic        overrun;

  logic [7:0]  mem [1024];
  int          cyc;
  int          checks;
  int          failures;

  typedef struct {
    int    cyc;
    int    sig;
    int    exp;
    string name;
  } chk_t;

  chk_t sb[$];

  text_line_cache dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .px_x      (px_x),
    .px_y      (px_y),
    .eof       (eof),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .char_code (char_code),
    .char_inv  (char_inv),
    .off_limits(off_limits),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Char memory with one cycle of read latency.
  always @(posedge clk) mem_data <= mem[mem_addr[9:0]];

  function automatic int sample(input int sig);
    case (sig)
      SIG_CODE: return int'(char_code);
      SIG_INV:  return int'(char_inv);
      SIG_OFF:  return int'(off_limits);
      SIG_BUSY: return int'(busy);
      SIG_OVR:  return int'(overrun);
      SIG_ADDR: return int'(mem_addr);
      default:  return -1;
    endcase
  endfunction

  task automatic expect_at(input int due, input int sig, input int exp, input string name);
    chk_t e;
    int   pos;
    e.cyc  = due;
    e.sig  = sig;
    e.exp  = exp;
    e.name = name;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > due) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int x, input int y, input int code, input int inv, input int off,
                       input string name);
    px_x = 10'(x);
    px_y = 9'(y);
    expect_at(cyc + 1, SIG_CODE, code, {name, "_code"});
    expect_at(cyc + 1, SIG_INV,  inv,  {name, "_inv"});
    expect_at(cyc + 1, SIG_OFF,  off,  {name, "_off"});
    tick();
  endtask

  // Monitor: pops every entry due by now and compares it with the live output.
  initial begin
    chk_t e;
    int   act;
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e   = sb.pop_front();
        act = sample(e.sig);
        checks++;
        if (e.cyc != cyc || act != e.exp) begin
          failures++;
          $display("FAIL %s cyc=%0d due=%0d actual=%0d required=%0d", e.name, cyc, e.cyc, act, e.exp);
        end else begin
          $display("ok   %s cyc=%0d value=%0d", e.name, cyc, act);
        end
      end
    end
  end

  initial begin
    int t;
    int guard;
    chk_t e;
    rst  = 1'b1;
    en   = 1'b0;
    px_x = '0;
    px_y = '0;
    eof  = 1'b0;
    for (int a = 0; a < 1024; a++)
      mem[a] = 8'(a & 'h7F) | (((a & 4) != 0) ? 8'h80 : 8'h00);
    mem[0] = 8'hC1;

    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL direct_rst_busy actual=%0b required=0", busy);
    end else begin
      $display("ok   direct_rst_busy value=%0b", busy);
    end
    checks++;
    if (mem_addr !== 13'd0) begin
      failures++;
      $display("FAIL direct_rst_addr actual=%0d required=0", mem_addr);
    end else begin
      $display("ok   direct_rst_addr value=%0d", mem_addr);
    end
    checks++;
    if (off_limits !== 1'b1) begin
      failures++;
      $display("FAIL direct_rst_off actual=%0b required=1", off_limits);
    end else begin
      $display("ok   direct_rst_off value=%0b", off_limits);
    end
    checks++;
    if (char_code !== 7'd0) begin
      failures++;
      $display("FAIL direct_rst_code actual=%0d required=0", char_code);
    end else begin
      $display("ok   direct_rst_code value=%0d", char_code);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL direct_rst_ovr actual=%0b required=0", overrun);
    end else begin
      $display("ok   direct_rst_ovr value=%0b", overrun);
    end
    expect_at(cyc, SIG_BUSY, 0, "rst_busy");
    expect_at(cyc, SIG_ADDR, 0, "rst_addr");
    expect_at(cyc, SIG_OFF,  1, "rst_off");
    expect_at(cyc, SIG_CODE, 0, "rst_code");
    expect_at(cyc, SIG_INV,  0, "rst_inv");
    expect_at(cyc, SIG_OVR,  0, "rst_ovr");
    tick();
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) tick();

    // Frame start: fill row 0, 44 busy cycles.
    eof = 1'b1;
    t = cyc;
    expect_at(t + 1,  SIG_BUSY, 1,  "f0_busy_start");
    expect_at(t + 1,  SIG_ADDR, 0,  "f0_addr_first");
    expect_at(t + 42, SIG_ADDR, 41, "f0_addr_last");
    expect_at(t + 44, SIG_BUSY, 1,  "f0_busy_swap");
    expect_at(t + 45, SIG_BUSY, 0,  "f0_busy_end");
    expect_at(t + 45, SIG_ADDR, 41, "f0_addr_hold");
    tick();
    eof = 1'b0;
    repeat (8) tick();
    probe(15, 0, 0, 0, 0, "f0_before_swap");
    while (cyc < t + 45) tick();
    probe(15, 0, 1, 0, 0, "f0_cell1");
    probe(0, 0, 'h41, ATTR, 0, "f0_attr_cell0");

    // Row 1 fill triggered at the end of scanline 20.
    px_x = 10'd639;
    px_y = 9'd20;
    tick();
    px_x = 10'd640;
    t = cyc;
    expect_at(t + 1,  SIG_ADDR, 42, "r1_addr_first");
    expect_at(t + 42, SIG_ADDR, 83, "r1_addr_last");
    expect_at(t + 43, SIG_ADDR, 83, "r1_addr_hold");
    expect_at(t + 44, SIG_BUSY, 1,  "r1_busy_swap");
    while (cyc < t + 45) tick();
    probe(0, 21, 42, 0, 0, "r1_cell0");

    // Last text scanline: no row 22 fill.
    px_x = 10'd639;
    px_y = 9'd461;
    tick();
    px_x = 10'd640;
    expect_at(cyc + 1, SIG_BUSY, 0, "no_row22");
    repeat (2) tick();

    // Row 21 fill, reaching the top address.
    px_x = 10'd639;
    px_y = 9'd440;
    tick();
    px_x = 10'd640;
    t = cyc;
    expect_at(t + 1,  SIG_ADDR, 882, "r21_addr_first");
    expect_at(t + 42, SIG_ADDR, 923, "r21_addr_last");
    expect_at(t + 43, SIG_ADDR, 923, "r21_addr_hold");
    while (cyc < t + 45) tick();
    probe(629, 461, 27, 0, 0, "corner");
    probe(630, 461, 0, 0, 1, "off_x");
    probe(629, 462, 0, 0, 1, "off_y");

    // Abort at column 10, restart at row 0, single swap.
    eof = 1'b1;
    t = cyc;
    tick();
    eof = 1'b0;
    while (cyc < t + 11) tick();
    eof = 1'b1;
    expect_at(cyc,    SIG_ADDR, 10, "abort_addr_col10");
    expect_at(t + 12, SIG_ADDR, 0,  "abort_restart0");
    expect_at(t + 13, SIG_ADDR, 1,  "abort_restart1");
    expect_at(t + 55, SIG_BUSY, 1,  "abort_busy_swap");
    expect_at(t + 56, SIG_BUSY, 0,  "abort_busy_end");
    tick();
    eof = 1'b0;
    while (cyc < t + 20) tick();
    probe(629, 461, 27, 0, 0, "abort_old_row");
    while (cyc < t + 56) tick();
    probe(15, 0, 1, 0, 0, "abort_row0");

    // Display wraps into row 1 while row 1 is still filling.
    expect_at(cyc, SIG_OVR, 0, "ovr_clear");
    px_x = 10'd639;
    px_y = 9'd20;
    tick();
    px_x = 10'd640;
    t = cyc;
    tick();
    px_x = 10'd0;
    px_y = 9'd21;
    expect_at(t + 1, SIG_OVR,  0, "ovr_before");
    expect_at(t + 2, SIG_OVR,  1, "ovr_set");
    expect_at(t + 2, SIG_BUSY, 1, "ovr_busy");
    while (cyc < t + 50) tick();
    expect_at(cyc, SIG_OVR, 1, "ovr_sticky");
    tick();

    // Enable low: fill stops, outputs blanked, triggers ignored.
    eof = 1'b1;
    t = cyc;
    tick();
    eof = 1'b0;
    repeat (4) tick();
    en   = 1'b0;
    px_x = 10'd15;
    px_y = 9'd0;
    expect_at(cyc + 1, SIG_BUSY, 0, "en_busy");
    expect_at(cyc + 1, SIG_CODE, 0, "en_code");
    expect_at(cyc + 1, SIG_OFF,  1, "en_off");
    expect_at(cyc + 1, SIG_OVR,  1, "en_ovr_kept");
    tick();
    eof = 1'b1;
    expect_at(cyc + 1, SIG_BUSY, 0, "en_eof_ignored");
    tick();
    eof = 1'b0;
    en  = 1'b1;
    tick();

    // Reset clears overrun and the line buffers.
    rst = 1'b1;
    expect_at(cyc, SIG_OVR,  0, "rst2_ovr");
    expect_at(cyc, SIG_BUSY, 0, "rst2_busy");
    expect_at(cyc, SIG_ADDR, 0, "rst2_addr");
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL direct_rst2_ovr actual=%0b required=0", overrun);
    end else begin
      $display("ok   direct_rst2_ovr value=%0b", overrun);
    end
    rst = 1'b0;
    tick();
    probe(15, 0, 0, 0, 0, "rst2_buf_cleared");

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      tick();
      guard++;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s never_checked actual=none required=%0d", e.name, e.exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
